// File: rtl/branch_resolve_unit.sv
// Branch resolution back end: tracks resolved branches per ROB tag, raises the flush/redirect on
// commit of a mispredicted entry, and trains a 2-bit-counter BHT read combinationally by fetch.
module branch_resolve_unit #(
    parameter int unsigned ROB_DEPTH   = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 32,
    localparam int unsigned TAG_W      = $clog2(ROB_DEPTH),
    localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bp_valid,
    input  logic [TAG_W-1:0] bp_rob_tag,
    input  logic             bp_mispredict,
    input  logic [31:0]      bp_pc,
    input  logic             prediction_valid,
    input  logic             prediction_result,
    input  logic [31:0]      prediction_pc,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_rob_tag,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_pred_taken,
    output logic             branch_mispredicted,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [ROB_DEPTH-1:0] resolved;
    logic [ROB_DEPTH-1:0] mispredict;
    logic [31:0]          target [ROB_DEPTH];
    logic [1:0]           bht    [BHT_ENTRIES];

    logic             bypass;
    logic             commit_hit;
    logic             commit_mis;
    logic [31:0]      commit_tgt;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] fetch_idx;

    always_comb begin
        bypass     = 1'b0;
        commit_hit = 1'b0;
        commit_mis = 1'b0;
        commit_tgt = '0;
        upd_idx    = prediction_pc[IDX_W+1:2];
        fetch_idx  = fetch_pc[IDX_W+1:2];
        // An entry resolved and committed in the same cycle never reaches the table.
        bypass     = bp_valid && commit_valid && (bp_rob_tag == commit_rob_tag);
        commit_hit = commit_valid && !branch_mispredicted && (bypass || resolved[commit_rob_tag]);
        commit_mis = bypass ? bp_mispredict : mispredict[commit_rob_tag];
        commit_tgt = bypass ? bp_pc : target[commit_rob_tag];
    end

    assign fetch_pred_taken = bht[fetch_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            resolved            <= '0;
            mispredict          <= '0;
            branch_mispredicted <= 1'b0;
            redirect_pc         <= '0;
            branch_count        <= '0;
            mispredict_count    <= '0;
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                target[i] <= '0;
            end
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            branch_mispredicted <= 1'b0;
            if (branch_mispredicted) begin
                resolved   <= '0;
                mispredict <= '0;
            end else begin
                if (bp_valid && !bypass) begin
                    resolved[bp_rob_tag]   <= 1'b1;
                    mispredict[bp_rob_tag] <= bp_mispredict;
                    target[bp_rob_tag]     <= bp_pc;
                end
                if (commit_hit) begin
                    branch_count <= branch_count + CNT_ONE;
                    if (!bypass) begin
                        resolved[commit_rob_tag]   <= 1'b0;
                        mispredict[commit_rob_tag] <= 1'b0;
                    end
                    if (commit_mis) begin
                        mispredict_count    <= mispredict_count + CNT_ONE;
                        branch_mispredicted <= 1'b1;
                        redirect_pc         <= commit_tgt;
                    end
                end
                if (prediction_valid) begin
                    if (prediction_result && bht[upd_idx] != 2'b11) begin
                        bht[upd_idx] <= bht[upd_idx] + 2'b01;
                    end else if (!prediction_result && bht[upd_idx] != 2'b00) begin
                        bht[upd_idx] <= bht[upd_idx] - 2'b01;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: flush/redirect, counters, bypass, flush-cycle masking, BHT.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        bp_valid;
    logic [4:0]  bp_rob_tag;
    logic        bp_mispredict;
    logic [31:0] bp_pc;
    logic        prediction_valid;
    logic        prediction_result;
    logic [31:0] prediction_pc;
    logic        commit_valid;
    logic [4:0]  commit_rob_tag;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        branch_mispredicted;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int passes = 0;

    branch_resolve_unit #(
        .ROB_DEPTH  (32),
        .BHT_ENTRIES(64),
        .CNT_W      (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bp_valid           (bp_valid),
        .bp_rob_tag         (bp_rob_tag),
        .bp_mispredict      (bp_mispredict),
        .bp_pc              (bp_pc),
        .prediction_valid   (prediction_valid),
        .prediction_result  (prediction_result),
        .prediction_pc      (prediction_pc),
        .commit_valid       (commit_valid),
        .commit_rob_tag     (commit_rob_tag),
        .fetch_pc           (fetch_pc),
        .fetch_pred_taken   (fetch_pred_taken),
        .branch_mispredicted(branch_mispredicted),
        .redirect_pc        (redirect_pc),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bp_valid = 0; bp_rob_tag = '0; bp_mispredict = 0; bp_pc = '0;
        prediction_valid = 0; prediction_result = 0; prediction_pc = '0;
        commit_valid = 0; commit_rob_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic resolve(input logic [4:0] tag, input logic mis, input logic [31:0] pc);
        bp_valid = 1; bp_rob_tag = tag; bp_mispredict = mis; bp_pc = pc;
    endtask

    task automatic commit(input logic [4:0] tag);
        commit_valid = 1; commit_rob_tag = tag;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken);
        prediction_valid = 1; prediction_pc = pc; prediction_result = taken;
    endtask

    task automatic check_state(input string tag, input logic bm, input logic [31:0] bc,
                               input logic [31:0] mc);
        check({tag, "_flush"}, 32'(branch_mispredicted), 32'(bm));
        check({tag, "_bcnt"}, branch_count, bc);
        check({tag, "_mcnt"}, mispredict_count, mc);
    endtask

    initial begin
        fetch_pc = 32'h1000;
        do_reset();

        // 1: reset state
        check_state("rst", 0, 0, 0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_pred", 32'(fetch_pred_taken), 0);

        // 2: mispredict commit two cycles after resolve; flush cycle masks BHT training
        resolve(5, 1, 32'h2040); tick();
        idle(); tick();
        commit(5); tick();
        idle();
        check_state("t2_flush", 1, 1, 1);
        check("t2_redirect", redirect_pc, 32'h2040);
        train(32'h200, 1); tick();
        idle();
        check_state("t2_after", 0, 1, 1);
        check("t2_redirect_hold", redirect_pc, 32'h2040);
        fetch_pc = 32'h200; #1;
        check("t2_bht_masked", 32'(fetch_pred_taken), 0);

        // 3: correct prediction counts, unresolved commit ignored
        do_reset();
        resolve(7, 0, 32'h1234); tick();
        idle(); commit(7); tick();
        idle();
        check_state("t3_ok", 0, 1, 0);
        commit(9); tick();
        idle();
        check_state("t3_unres", 0, 1, 0);

        // 4: same-cycle bypass
        do_reset();
        resolve(3, 1, 32'h80); commit(3); tick();
        idle();
        check_state("t4_bypass", 1, 1, 1);
        check("t4_redirect", redirect_pc, 32'h80);
        tick();
        resolve(4, 0, 32'h90); commit(4); tick();
        idle();
        check_state("t4_bypass_ok", 0, 2, 1);
        commit(4); tick();
        idle();
        check_state("t4_no_write", 0, 2, 1);

        // 5: BHT saturating training
        do_reset();
        fetch_pc = 32'h100; #1;
        check("t5_init", 32'(fetch_pred_taken), 0);
        train(32'h100, 1); #1;
        check("t5_pre_update", 32'(fetch_pred_taken), 0);
        tick();
        check("t5_taken1", 32'(fetch_pred_taken), 1);
        tick(); tick();
        check("t5_taken3", 32'(fetch_pred_taken), 1);
        train(32'h100, 0); tick();
        check("t5_sat_hi", 32'(fetch_pred_taken), 1);
        tick();
        check("t5_nt2", 32'(fetch_pred_taken), 0);
        tick(); tick();
        train(32'h100, 1); tick();
        idle();
        check("t5_sat_lo", 32'(fetch_pred_taken), 0);
        fetch_pc = 32'h104; #1;
        check("t5_other_idx", 32'(fetch_pred_taken), 0);

        // 6: flush clears table; bp/commit in flush cycle ignored
        do_reset();
        resolve(1, 1, 32'h300); tick();
        resolve(2, 1, 32'h400); tick();
        idle(); commit(1); tick();
        idle();
        check_state("t6_flush", 1, 1, 1);
        check("t6_redirect", redirect_pc, 32'h300);
        resolve(10, 1, 32'h500); commit(2); tick();
        idle();
        check_state("t6_masked", 0, 1, 1);
        commit(2); tick();
        idle();
        check_state("t6_cleared", 0, 1, 1);
        commit(10); tick();
        idle();
        check_state("t6_bp_masked", 0, 1, 1);
        check("t6_redirect_hold", redirect_pc, 32'h300);

        // mid-operation reset dominates a pending mispredict commit
        resolve(6, 1, 32'h600); tick();
        idle(); commit(6); rst = 1; tick();
        rst = 0; idle();
        check_state("midrst", 0, 0, 0);
        check("midrst_redirect", redirect_pc, 32'h0);
        commit(6); tick();
        idle();
        check_state("midrst_cleared", 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
